// File: rtl/mac_tap_sequencer.sv
// Time-shares one pipelined MAC across NTAPS products per sample, then loads y(k),
// shifts the sample history and flags dropped samples and accumulator saturation.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for datolisto
// S_CLEAR | clear MAC accumulator and saturation accumulator
// S_ISSUE | one tap per cycle, tap_sel = tap counter
// S_DRAIN | wait out the MAC pipeline latency
// S_LOAD  | latch accumulator into y(k), capture sat_flag
// S_SHIFT | shift sample history f(k)->f(k-1)->f(k-2)
// S_DONE  | operacionlisto pulse
module mac_tap_sequencer #(
   parameter int NTAPS   = 5,
   parameter int MAC_LAT = 3,
   parameter int TAPW    = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            datolisto,
   input  logic            sat_in,
   input  logic            clr_overrun,
   output logic            mac_clr,
   output logic            mac_en,
   output logic [TAPW-1:0] tap_sel,
   output logic            out_load,
   output logic            hist_shift,
   output logic            operacionlisto,
   output logic            busy,
   output logic            overrun,
   output logic            sat_flag
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_LOAD, S_SHIFT, S_DONE
   } state_t;

   localparam logic [TAPW-1:0] TAP_LAST   = TAPW'(NTAPS - 1);
   localparam logic [3:0]      DRAIN_INIT = (MAC_LAT > 0) ? 4'(MAC_LAT - 1) : 4'd0;

   state_t          state_q, state_d;
   logic [TAPW-1:0] tap_q, tap_d;
   logic [3:0]      drain_q, drain_d;
   logic            sat_acc_q, sat_acc_d;
   logic            sat_flag_q, sat_flag_d;
   logic            overrun_q, overrun_d;
   logic            mac_clr_q, mac_clr_d;
   logic            mac_en_q, mac_en_d;
   logic            out_load_q, out_load_d;
   logic            hist_shift_q, hist_shift_d;
   logic            op_listo_q, op_listo_d;
   logic            busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      drain_d    = drain_q;
      sat_acc_d  = sat_acc_q;
      sat_flag_d = sat_flag_q;
      case (state_q)
         S_IDLE:  if (datolisto) state_d = S_CLEAR;
         S_CLEAR: begin
            tap_d     = '0;
            sat_acc_d = 1'b0;
            state_d   = S_ISSUE;
         end
         S_ISSUE: begin
            sat_acc_d = sat_acc_q | sat_in;
            // Counter returns to 0 on exit so tap_sel reads 0 outside ISSUE.
            if (tap_q == TAP_LAST) begin
               tap_d   = '0;
               drain_d = DRAIN_INIT;
               state_d = (MAC_LAT == 0) ? S_LOAD : S_DRAIN;
            end else begin
               tap_d = tap_q + TAPW'(1);
            end
         end
         S_DRAIN: begin
            sat_acc_d = sat_acc_q | sat_in;
            if (drain_q == 4'd0) state_d = S_LOAD;
            else                 drain_d = drain_q - 4'd1;
         end
         S_LOAD: begin
            sat_acc_d  = sat_acc_q | sat_in;
            sat_flag_d = sat_acc_q | sat_in;
            state_d    = S_SHIFT;
         end
         S_SHIFT: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            tap_d   = '0;
            drain_d = 4'd0;
         end
      endcase

      // A dropped strobe outranks a simultaneous clear.
      overrun_d = overrun_q;
      if (datolisto && (state_q != S_IDLE)) overrun_d = 1'b1;
      else if (clr_overrun)                 overrun_d = 1'b0;

      mac_clr_d    = (state_d == S_CLEAR);
      mac_en_d     = (state_d == S_ISSUE);
      out_load_d   = (state_d == S_LOAD);
      hist_shift_d = (state_d == S_SHIFT);
      op_listo_d   = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tap_q        <= '0;
         drain_q      <= 4'd0;
         sat_acc_q    <= 1'b0;
         sat_flag_q   <= 1'b0;
         overrun_q    <= 1'b0;
         mac_clr_q    <= 1'b0;
         mac_en_q     <= 1'b0;
         out_load_q   <= 1'b0;
         hist_shift_q <= 1'b0;
         op_listo_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         drain_q      <= drain_d;
         sat_acc_q    <= sat_acc_d;
         sat_flag_q   <= sat_flag_d;
         overrun_q    <= overrun_d;
         mac_clr_q    <= mac_clr_d;
         mac_en_q     <= mac_en_d;
         out_load_q   <= out_load_d;
         hist_shift_q <= hist_shift_d;
         op_listo_q   <= op_listo_d;
         busy_q       <= busy_d;
      end
   end

   assign mac_clr        = mac_clr_q;
   assign mac_en         = mac_en_q;
   assign tap_sel        = tap_q;
   assign out_load       = out_load_q;
   assign hist_shift     = hist_shift_q;
   assign operacionlisto = op_listo_q;
   assign busy           = busy_q;
   assign overrun        = overrun_q;
   assign sat_flag       = sat_flag_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Bench for mac_tap_sequencer: default config and NTAPS=1/MAC_LAT=0 driven in parallel,
// compared every cycle against a timing-table model plus a completion-cycle scoreboard.
module tb_mac_tap_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0, datolisto = 1'b0, sat_in = 1'b0, clr_overrun = 1'b0;
   always #5 clk = ~clk;

   logic       a_clr, a_en, a_load, a_shift, a_done, a_busy, a_ovr, a_sat;
   logic [2:0] a_tap;
   logic       b_clr, b_en, b_load, b_shift, b_done, b_busy, b_ovr, b_sat;
   logic [2:0] b_tap;

   mac_tap_sequencer #(.NTAPS(5), .MAC_LAT(3), .TAPW(3)) dut_a (
      .clk(clk), .reset(reset), .datolisto(datolisto), .sat_in(sat_in),
      .clr_overrun(clr_overrun), .mac_clr(a_clr), .mac_en(a_en), .tap_sel(a_tap),
      .out_load(a_load), .hist_shift(a_shift), .operacionlisto(a_done),
      .busy(a_busy), .overrun(a_ovr), .sat_flag(a_sat));

   mac_tap_sequencer #(.NTAPS(1), .MAC_LAT(0), .TAPW(3)) dut_b (
      .clk(clk), .reset(reset), .datolisto(datolisto), .sat_in(sat_in),
      .clr_overrun(clr_overrun), .mac_clr(b_clr), .mac_en(b_en), .tap_sel(b_tap),
      .out_load(b_load), .hist_shift(b_shift), .operacionlisto(b_done),
      .busy(b_busy), .overrun(b_ovr), .sat_flag(b_sat));

   // {mac_clr, mac_en, tap_sel[2:0], out_load, hist_shift, operacionlisto, busy, overrun, sat_flag}
   logic [10:0] obs [2];
   assign obs[0] = {a_clr, a_en, a_tap, a_load, a_shift, a_done, a_busy, a_ovr, a_sat};
   assign obs[1] = {b_clr, b_en, b_tap, b_load, b_shift, b_done, b_busy, b_ovr, b_sat};

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int NT [2] = '{5, 1};
   int ML [2] = '{3, 0};
   bit act [2];
   int t0 [2];
   bit ov [2], sacc [2], sflg [2];
   int q0 [$];
   int q1 [$];

   task automatic model_step(input int i, input logic dl, input logic s, input logic cl,
                             input logic r, input int c);
      int  len, off;
      bit  idle;
      if (r) begin
         act[i] = 0; ov[i] = 0; sacc[i] = 0; sflg[i] = 0;
         if (i == 0) q0.delete(); else q1.delete();
         return;
      end
      len  = NT[i] + ML[i] + 5;
      off  = c - t0[i];
      idle = !act[i] || (off >= len);
      if (!idle) begin
         if (off == 1) sacc[i] = 0;
         else if (off >= 2 && off <= NT[i] + ML[i] + 2) begin
            if (off == NT[i] + ML[i] + 2) sflg[i] = sacc[i] | s;
            sacc[i] = sacc[i] | s;
         end
      end
      if (dl && !idle)  ov[i] = 1;
      else if (cl)      ov[i] = 0;
      if (idle && dl) begin
         act[i] = 1;
         t0[i]  = c;
         if (i == 0) q0.push_back(c + len - 1); else q1.push_back(c + len - 1);
      end
   endtask

   function automatic logic [10:0] exp_vec(input int i, input int n);
      int off, ld;
      logic [10:0] v;
      v   = '0;
      off = n - t0[i];
      ld  = NT[i] + ML[i] + 2;
      if (act[i] && off >= 1 && off <= ld + 2) begin
         v[10] = (off == 1);
         if (off >= 2 && off <= NT[i] + 1) begin
            v[9]   = 1'b1;
            v[8:6] = 3'(off - 2);
         end
         v[5] = (off == ld);
         v[4] = (off == ld + 1);
         v[3] = (off == ld + 2);
         v[2] = 1'b1;
      end
      v[1] = ov[i];
      v[0] = sflg[i];
      return v;
   endfunction

   task automatic tick(input logic dl, input logic s, input logic cl, input logic r);
      logic [10:0] e;
      int          want;
      datolisto = dl; sat_in = s; clr_overrun = cl; reset = r;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_step(i, dl, s, cl, r, cyc);
      cyc++;
      datolisto = 1'b0; sat_in = 1'b0; clr_overrun = 1'b0; reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = exp_vec(i, cyc);
         checks++;
         assert (obs[i] === e) else begin
            failures++;
            $error("FAIL outputs inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], e);
         end
         if (obs[i][3] === 1'b1) begin
            want = -1;
            if (i == 0 && q0.size() > 0) want = q0.pop_front();
            if (i == 1 && q1.size() > 0) want = q1.pop_front();
            checks++;
            assert (cyc === want) else begin
               failures++;
               $error("FAIL done_cycle inst=%0d got=%0d exp=%0d", i, cyc, want);
            end
         end
      end
   endtask

   task automatic idle_n(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      idle_n(2);

      // single sample, default timing
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(14);

      // dropped pulse mid-sequence, clear, then simultaneous clear and drop
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(4);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(14);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle_n(2);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(1);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      idle_n(12);
      tick(1'b0, 1'b0, 1'b1, 1'b0);

      // next sample in the IDLE right after DONE, then a pulse during DONE
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(12);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(14);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(11);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(3);
      tick(1'b0, 1'b0, 1'b1, 1'b0);

      // saturation during drain, then a clean sample
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(7);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      idle_n(6);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(14);

      // reset mid-sequence, then restart
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(3);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      idle_n(3);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(14);

      for (int k = 0; k < 400; k++)
         tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 150) == 0);
      idle_n(20);

      checks++;
      assert (q0.size() === 0) else begin
         failures++;
         $error("FAIL pending_a got=%0d exp=0", q0.size());
      end
      checks++;
      assert (q1.size() === 0) else begin
         failures++;
         $error("FAIL pending_b got=%0d exp=0", q1.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
